// File: rtl/machinev_pkg.sv
// Shared MachineV constants: bus widths, memory FSM state encoding and read-latency counter sizing.
// Imported by the core-side and memory-side files alike.
package machinev_pkg;

    localparam int MV_ADDR_W = 5;
    localparam int MV_DATA_W = 8;

    // Names the MachineV core uses for the same bus widths.
    localparam int MV_ABUS_W = MV_ADDR_W;
    localparam int MV_DBUS_W = MV_DATA_W;

    // READ_LAT is limited to 1..7, so the countdown fits in three bits.
    localparam int MV_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RWAIT  = 2'd1,
        ST_RDRIVE = 2'd2,
        ST_WACK   = 2'd3
    } mem_state_e;

    function automatic logic [MV_CNT_W-1:0] lat_to_cnt(input int lat);
        return MV_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/machinev_memory_if.sv
// CPU strobe/handshake and side-loader signals of the MachineV memory.
// The shared Dbus is tri-state and travels as a separate inout port.
interface machinev_memory_if
    import machinev_pkg::*;
#(
    parameter int ADDR_W = MV_ADDR_W,
    parameter int DATA_W = MV_DATA_W
);
    logic [ADDR_W-1:0] Abus;
    logic              rd;
    logic              wr;
    logic              ready;
    logic              err;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output Abus, rd, wr, ld_en, ld_addr, ld_data,
        input  ready, err
    );

    modport slave (
        input  Abus, rd, wr, ld_en, ld_addr, ld_data,
        output ready, err
    );
endinterface

// File: rtl/machinev_ram_array.sv
// Plain 2**ADDR_W x DATA_W storage: one synchronous write port, registered read.
// No reset on the array or the read register so it maps onto block RAM.
module machinev_ram_array
    import machinev_pkg::*;
#(
    parameter int ADDR_W = MV_ADDR_W,
    parameter int DATA_W = MV_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

endmodule

// File: rtl/machinev_memory.sv
// MachineV bus-responder memory: answers CPU rd/wr strobes with ready and drives Dbus only in RDRIVE.
// Define MACHINEV_MEM_WRPROT_EN to reject CPU writes below PROT_LIMIT (loader writes stay unprotected).
module machinev_memory
    import machinev_pkg::*;
#(
    parameter int ADDR_W     = MV_ADDR_W,
    parameter int DATA_W     = MV_DATA_W,
    parameter int READ_LAT   = 1,
    parameter int PROT_LIMIT = 8
) (
    input  logic               CLK,
    input  logic               RST,
    machinev_memory_if.slave   bus,
    inout  wire [DATA_W-1:0]   Dbus
);

`ifdef MACHINEV_MEM_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    localparam logic [MV_CNT_W-1:0] CNT_INIT = lat_to_cnt(READ_LAT);

    mem_state_e           state_q, state_d;
    logic [MV_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 err_q, err_d;

    logic                 we;
    logic                 re;
    logic [ADDR_W-1:0]    waddr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;
    logic                 wr_protected;

    assign wr_protected = PROT_EN && (bus.Abus < ADDR_W'(PROT_LIMIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        waddr   = bus.ld_addr;
        wdata   = bus.ld_data;

        case (state_q)
            ST_IDLE: begin
                // The loader owns the cycle; CPU strobes stay held and are taken next edge.
                if (bus.ld_en) begin
                    we = 1'b1;
                end else if (bus.rd && bus.wr) begin
                    err_d = 1'b1;
                end else if (bus.rd) begin
                    addr_d  = bus.Abus;
                    cnt_d   = CNT_INIT;
                    state_d = ST_RWAIT;
                end else if (bus.wr) begin
                    waddr   = bus.Abus;
                    wdata   = Dbus;
                    we      = !wr_protected;
                    err_d   = wr_protected;
                    state_d = ST_WACK;
                end
            end
            ST_RWAIT: begin
                if (!bus.rd) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    re      = 1'b1;
                    state_d = ST_RDRIVE;
                end else begin
                    cnt_d = cnt_q - MV_CNT_W'(1);
                end
            end
            ST_RDRIVE: begin
                if (!bus.rd) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WACK: begin
                if (!bus.wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // The array has no reset, so a write that lands on an edge with RST high must be suppressed here.
    machinev_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (CLK),
        .we      (we && !RST),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re && !RST),
        .raddr   (addr_q),
        .rdata_q (rdata)
    );

    assign bus.ready = (state_q == ST_RDRIVE) || ((state_q == ST_WACK) && bus.wr);
    assign bus.err   = err_q;
    assign Dbus      = (state_q == ST_RDRIVE) ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_machinev_memory.sv
// Directed bench for machinev_memory: instance A uses READ_LAT=1, instance B uses READ_LAT=3.
// Both data buses carry pull-ups, so a released (high-Z) Dbus reads back as 8'hFF.
module tb_machinev_memory;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    machinev_memory_if #(.ADDR_W(5), .DATA_W(8)) bus_a ();
    machinev_memory_if #(.ADDR_W(5), .DATA_W(8)) bus_b ();

    wire  [7:0] dbus_a;
    wire  [7:0] dbus_b;
    logic       cpu_oe  = 1'b0;
    logic [7:0] cpu_dat = 8'h00;

    pullup (dbus_a);
    pullup (dbus_b);
    assign dbus_a = cpu_oe ? cpu_dat : 8'hzz;

    int n_cmp = 0;
    int n_bad = 0;

    machinev_memory #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .PROT_LIMIT(8)) dut_a (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus_a),
        .Dbus (dbus_a)
    );

    machinev_memory #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3), .PROT_LIMIT(8)) dut_b (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus_b),
        .Dbus (dbus_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input bit use_b, input logic [4:0] a, input logic [7:0] d);
        if (use_b) begin
            bus_b.ld_en = 1'b1; bus_b.ld_addr = a; bus_b.ld_data = d;
        end else begin
            bus_a.ld_en = 1'b1; bus_a.ld_addr = a; bus_a.ld_data = d;
        end
        tick();
        bus_a.ld_en = 1'b0;
        bus_b.ld_en = 1'b0;
    endtask

    // Edge count includes the accepting edge, so READ_LAT=1 gives 2 and READ_LAT=3 gives 4.
    task automatic do_read(input bit use_b, input logic [4:0] a, input logic [7:0] exp_d,
                           input int exp_edges, input string tag);
        int   edges = 0;
        logic rdy   = 1'b0;
        if (use_b) begin bus_b.Abus = a; bus_b.rd = 1'b1; end
        else       begin bus_a.Abus = a; bus_a.rd = 1'b1; end
        while (!rdy && edges < 20) begin
            tick();
            edges++;
            rdy = use_b ? bus_b.ready : bus_a.ready;
        end
        chk({tag, "_lat"}, edges, exp_edges);
        chk({tag, "_data"}, use_b ? dbus_b : dbus_a, exp_d);
        if (use_b) bus_b.rd = 1'b0;
        else       bus_a.rd = 1'b0;
        tick();
        chk({tag, "_rel"}, use_b ? {bus_b.ready, dbus_b} : {bus_a.ready, dbus_a}, 9'h0FF);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic exp_err,
                            input string tag);
        bus_a.Abus = a; cpu_dat = d; cpu_oe = 1'b1; bus_a.wr = 1'b1;
        tick();
        chk({tag, "_rdy"}, bus_a.ready, 1'b1);
        chk({tag, "_err"}, bus_a.err, exp_err);
        bus_a.wr = 1'b0; cpu_oe = 1'b0;
        tick();
        chk({tag, "_done"}, {bus_a.ready, bus_a.err}, 2'b00);
    endtask

    initial begin
        bus_a.Abus = '0; bus_a.rd = 1'b0; bus_a.wr = 1'b0;
        bus_a.ld_en = 1'b0; bus_a.ld_addr = '0; bus_a.ld_data = '0;
        bus_b.Abus = '0; bus_b.rd = 1'b0; bus_b.wr = 1'b0;
        bus_b.ld_en = 1'b0; bus_b.ld_addr = '0; bus_b.ld_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", bus_a.ready, 1'b0);
        chk("rst_err", bus_a.err, 1'b0);
        chk("rst_dbus", dbus_a, 8'hFF);
        #2 RST = 1'b0;
        tick();

        // Preload
        load(1'b0, 5'h03, 8'hA5);
        load(1'b0, 5'h1F, 8'h3C);
        load(1'b0, 5'h06, 8'h11);
        load(1'b0, 5'h02, 8'h22);
        load(1'b0, 5'h08, 8'h33);
        load(1'b1, 5'h04, 8'hC3);

        // Test 1: basic read, latency and bus release
        do_read(1'b0, 5'h03, 8'hA5, 2, "rd03");

        // Test 2: CPU write then read back; top-address read
        do_write(5'h10, 8'h5A, 1'b0, "wr10");
        do_read(1'b0, 5'h10, 8'h5A, 2, "rd10");
        do_read(1'b0, 5'h1F, 8'h3C, 2, "rd1f");

        // Test 3: rd/wr collision
        bus_a.Abus = 5'h03; cpu_dat = 8'h00; cpu_oe = 1'b1;
        bus_a.rd = 1'b1; bus_a.wr = 1'b1;
        tick();
        chk("coll_err", bus_a.err, 1'b1);
        chk("coll_ready", bus_a.ready, 1'b0);
        bus_a.rd = 1'b0; bus_a.wr = 1'b0; cpu_oe = 1'b0;
        tick();
        chk("coll_err_end", bus_a.err, 1'b0);
        do_read(1'b0, 5'h03, 8'hA5, 2, "coll_mem");

        // Test 4a: reset during RDRIVE
        bus_a.Abus = 5'h03; bus_a.rd = 1'b1;
        tick();
        tick();
        chk("rdrv_ready", bus_a.ready, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rstdrv", {bus_a.ready, dbus_a}, 9'h0FF);
        bus_a.rd = 1'b0;
        #1 RST = 1'b0;
        tick();
        do_read(1'b0, 5'h03, 8'hA5, 2, "rstdrv_rd");

        // Test 4b: reset during RWAIT on the READ_LAT=3 instance
        bus_b.Abus = 5'h04; bus_b.rd = 1'b1;
        tick();
        tick();
        chk("rwait_ready", bus_b.ready, 1'b0);
        #2 RST = 1'b1;
        #1;
        chk("rstwait", {bus_b.ready, dbus_b}, 9'h0FF);
        bus_b.rd = 1'b0;
        #1 RST = 1'b0;
        tick();
        chk("rstwait_idle", {bus_b.ready, dbus_b}, 9'h0FF);
        do_read(1'b1, 5'h04, 8'hC3, 4, "lat3");

        // Early rd release in RWAIT abandons the read
        bus_b.Abus = 5'h04; bus_b.rd = 1'b1;
        tick();
        bus_b.rd = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("abandon", {bus_b.ready, dbus_b}, 9'h0FF);

        // Test 5a: loader in the same cycle rd rises
        bus_a.ld_en = 1'b1; bus_a.ld_addr = 5'h05; bus_a.ld_data = 8'h77;
        bus_a.Abus = 5'h05; bus_a.rd = 1'b1;
        tick();
        chk("ldrd_e0", bus_a.ready, 1'b0);
        bus_a.ld_en = 1'b0;
        tick();
        chk("ldrd_e1", bus_a.ready, 1'b0);
        tick();
        chk("ldrd_e2", bus_a.ready, 1'b1);
        chk("ldrd_data", dbus_a, 8'h77);
        bus_a.rd = 1'b0;
        tick();

        // Test 5b: loader during RWAIT is ignored
        bus_a.Abus = 5'h06; bus_a.rd = 1'b1;
        tick();
        bus_a.ld_en = 1'b1; bus_a.ld_addr = 5'h06; bus_a.ld_data = 8'h99;
        tick();
        bus_a.ld_en = 1'b0;
        chk("ldwait_data", dbus_a, 8'h11);
        bus_a.rd = 1'b0;
        tick();
        do_read(1'b0, 5'h06, 8'h11, 2, "ldwait_mem");

        // Test 6: write protection
`ifdef MACHINEV_MEM_WRPROT_EN
        do_write(5'h02, 8'hFF, 1'b1, "prot02");
        do_read(1'b0, 5'h02, 8'h22, 2, "prot02_rd");
        do_write(5'h08, 8'hFF, 1'b0, "prot08");
        do_read(1'b0, 5'h08, 8'hFF, 2, "prot08_rd");
`else
        do_write(5'h02, 8'hFF, 1'b0, "open02");
        do_read(1'b0, 5'h02, 8'hFF, 2, "open02_rd");
        do_read(1'b0, 5'h08, 8'h33, 2, "open08_rd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
